// File: rtl/membus_arbiter_pkg.sv
// rtl/membus_arbiter_pkg.sv - shared types and address helper for the membus arbiter
//
// Package eei:
//   ArbMode       - arbitration policy (FIXED = highest index wins, RR = round-robin)
//   ChId          - channel identifier, sized for the 8-channel maximum
//   ram_word_addr - byte address to RAM word address (callers keep the low bits)
package eei;

  typedef enum logic {
    FIXED = 1'b0,
    RR    = 1'b1
  } ArbMode;

  localparam int MAX_CH = 8;

  typedef logic [$clog2(MAX_CH)-1:0] ChId;

  // Drops the byte-in-word offset; the caller truncates to its RAM address width.
  function automatic logic [63:0] ram_word_addr(input logic [63:0] addr, input int unsigned shift);
    return addr >> shift;
  endfunction

endpackage

// File: rtl/membus_arb_id_fifo.sv
// rtl/membus_arb_id_fifo.sv - in-order FIFO of channel IDs for response routing
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   push, push_id enqueue the channel that just won a slave handshake
//   pop           dequeue on each slave response
//   full, empty   occupancy flags
//   head          channel owning the oldest outstanding request
module membus_arb_id_fifo
  import eei::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  ChId  push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output ChId  head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  ChId           r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Explicit wrap keeps the pointers correct for any depth, including 1.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - N-channel arbiter onto a single-port RAM membus slave
//
// Ports:
//   clk, rst                               clock, synchronous active-low reset
//   m_valid/m_ready                        per-channel request handshake
//   m_addr/m_wen/m_wdata/m_wmask           packed per-channel request payloads
//   m_rvalid/m_rdata                       per-channel response valid, shared data
//   s_valid/s_ready/s_addr/s_wen/...       request to the RAM slave
//   s_rvalid/s_rdata                       response from the RAM slave
//   resp_err                               sticky: response with nothing outstanding
//   perf_grants/perf_stalls                per-channel 32-bit counters, only with
//                                          MEMBUS_ARB_PERF_EN defined
module membus_arbiter
  import eei::*;
#(
  parameter int NUM_CH          = 2,
  parameter int XLEN            = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int RAM_ADDR_WIDTH  = 16,
  parameter int ARB_MODE        = 0,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              m_valid,
  output logic [NUM_CH-1:0]              m_ready,
  input  logic [NUM_CH*XLEN-1:0]         m_addr,
  input  logic [NUM_CH-1:0]              m_wen,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   m_wdata,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] m_wmask,
  output logic [NUM_CH-1:0]              m_rvalid,
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic                           s_valid,
  input  logic                           s_ready,
  output logic [RAM_ADDR_WIDTH-1:0]      s_addr,
  output logic                           s_wen,
  output logic [DATA_WIDTH-1:0]          s_wdata,
  output logic [DATA_WIDTH/8-1:0]        s_wmask,
  input  logic                           s_rvalid,
  input  logic [DATA_WIDTH-1:0]          s_rdata,
  output logic                           resp_err
`ifdef MEMBUS_ARB_PERF_EN
  ,
  output logic [NUM_CH*32-1:0]           perf_grants,
  output logic [NUM_CH*32-1:0]           perf_stalls
`endif
);

  localparam int MW    = DATA_WIDTH / 8;
  localparam int SHIFT = $clog2(MW);

  logic            r_lock_vld;
  ChId             r_lock_id;
  ChId             r_rr_ptr;
  logic            r_resp_err;

  ChId             w_g;
  logic            w_found;
  logic            w_any_valid;
  logic            w_hs;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  ChId             w_head;
  logic [XLEN-1:0] w_addr;
  logic [63:0]     w_addr64;
  logic [63:0]     w_word_addr;

  // Winner selection; a registered lock holds the stalled winner steady.
  always_comb begin
    w_g     = '0;
    w_found = 1'b0;
    if (r_lock_vld) begin
      w_g = r_lock_id;
    end else if (ARB_MODE == int'(RR)) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        if (!w_found && m_valid[(int'(r_rr_ptr) + k) % NUM_CH]) begin
          w_g     = ChId'((int'(r_rr_ptr) + k) % NUM_CH);
          w_found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_valid[i]) begin
          w_g = ChId'(i);
        end
      end
    end
  end

  always_comb begin
    w_addr  = '0;
    s_wen   = 1'b0;
    s_wdata = '0;
    s_wmask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ChId'(i) == w_g) begin
        w_addr  = m_addr[i*XLEN +: XLEN];
        s_wen   = m_wen[i];
        s_wdata = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        s_wmask = m_wmask[i*MW +: MW];
      end
    end
  end

  assign w_addr64    = 64'(w_addr);
  assign w_word_addr = ram_word_addr(w_addr64, SHIFT);
  assign s_addr      = w_word_addr[RAM_ADDR_WIDTH-1:0];

  assign w_any_valid = |m_valid;
  // A full FIFO blocks grants even when a pop lands in the same cycle.
  assign s_valid     = w_any_valid && !w_fifo_full;
  assign w_hs        = s_valid && s_ready;

  always_comb begin
    m_ready  = '0;
    m_rvalid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ChId'(i) == w_g) begin
        m_ready[i] = w_hs;
      end
      if (ChId'(i) == w_head) begin
        m_rvalid[i] = s_rvalid && !w_fifo_empty;
      end
    end
  end

  assign m_rdata  = s_rdata;
  assign resp_err = r_resp_err;

  membus_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_hs),
    .push_id (w_g),
    .pop     (s_rvalid),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .head    (w_head)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
      r_rr_ptr   <= ChId'(NUM_CH - 1);
      r_resp_err <= 1'b0;
    end else begin
      if (w_hs) begin
        r_lock_vld <= 1'b0;
        r_rr_ptr   <= w_g;
      end else if (s_valid) begin
        r_lock_vld <= 1'b1;
        r_lock_id  <= w_g;
      end
      if (s_rvalid && w_fifo_empty) begin
        r_resp_err <= 1'b1;
      end
    end
  end

`ifdef MEMBUS_ARB_PERF_EN
  logic [NUM_CH*32-1:0] r_perf_grants;
  logic [NUM_CH*32-1:0] r_perf_stalls;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_grants <= '0;
      r_perf_stalls <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_valid[i] && m_ready[i]) begin
          r_perf_grants[i*32 +: 32] <= r_perf_grants[i*32 +: 32] + 32'd1;
        end
        if (m_valid[i] && !m_ready[i]) begin
          r_perf_stalls[i*32 +: 32] <= r_perf_stalls[i*32 +: 32] + 32'd1;
        end
      end
    end
  end

  assign perf_grants = r_perf_grants;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - directed self-checking bench for membus_arbiter
module tb_membus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // DUT A: 3 channels, round-robin
  logic [2:0]     a_m_valid;
  logic [2:0]     a_m_ready;
  logic [191:0]   a_m_addr;
  logic [2:0]     a_m_wen;
  logic [191:0]   a_m_wdata;
  logic [23:0]    a_m_wmask;
  logic [2:0]     a_m_rvalid;
  logic [63:0]    a_m_rdata;
  logic           a_s_valid;
  logic           a_s_ready;
  logic [15:0]    a_s_addr;
  logic           a_s_wen;
  logic [63:0]    a_s_wdata;
  logic [7:0]     a_s_wmask;
  logic           a_s_rvalid;
  logic [63:0]    a_s_rdata;
  logic           a_resp_err;

  // DUT B: 2 channels, fixed priority
  logic [1:0]     b_m_valid;
  logic [1:0]     b_m_ready;
  logic [127:0]   b_m_addr;
  logic [1:0]     b_m_wen;
  logic [127:0]   b_m_wdata;
  logic [15:0]    b_m_wmask;
  logic [1:0]     b_m_rvalid;
  logic [63:0]    b_m_rdata;
  logic           b_s_valid;
  logic           b_s_ready;
  logic [15:0]    b_s_addr;
  logic           b_s_wen;
  logic [63:0]    b_s_wdata;
  logic [7:0]     b_s_wmask;
  logic           b_s_rvalid;
  logic [63:0]    b_s_rdata;
  logic           b_resp_err;

`ifdef MEMBUS_ARB_PERF_EN
  logic [95:0]    a_perf_grants;
  logic [95:0]    a_perf_stalls;
  logic [63:0]    b_perf_grants;
  logic [63:0]    b_perf_stalls;
`endif

  membus_arbiter #(
    .NUM_CH(3), .XLEN(64), .DATA_WIDTH(64), .RAM_ADDR_WIDTH(16),
    .ARB_MODE(1), .MAX_OUTSTANDING(2)
  ) dut_a (
    .clk(clk), .rst(rst),
    .m_valid(a_m_valid), .m_ready(a_m_ready), .m_addr(a_m_addr),
    .m_wen(a_m_wen), .m_wdata(a_m_wdata), .m_wmask(a_m_wmask),
    .m_rvalid(a_m_rvalid), .m_rdata(a_m_rdata),
    .s_valid(a_s_valid), .s_ready(a_s_ready), .s_addr(a_s_addr),
    .s_wen(a_s_wen), .s_wdata(a_s_wdata), .s_wmask(a_s_wmask),
    .s_rvalid(a_s_rvalid), .s_rdata(a_s_rdata), .resp_err(a_resp_err)
`ifdef MEMBUS_ARB_PERF_EN
    , .perf_grants(a_perf_grants), .perf_stalls(a_perf_stalls)
`endif
  );

  membus_arbiter #(
    .NUM_CH(2), .XLEN(64), .DATA_WIDTH(64), .RAM_ADDR_WIDTH(16),
    .ARB_MODE(0), .MAX_OUTSTANDING(2)
  ) dut_b (
    .clk(clk), .rst(rst),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_addr(b_m_addr),
    .m_wen(b_m_wen), .m_wdata(b_m_wdata), .m_wmask(b_m_wmask),
    .m_rvalid(b_m_rvalid), .m_rdata(b_m_rdata),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_addr(b_s_addr),
    .s_wen(b_s_wen), .s_wdata(b_s_wdata), .s_wmask(b_s_wmask),
    .s_rvalid(b_s_rvalid), .s_rdata(b_s_rdata), .resp_err(b_resp_err)
`ifdef MEMBUS_ARB_PERF_EN
    , .perf_grants(b_perf_grants), .perf_stalls(b_perf_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int exp_g;

    a_m_valid  = '0; a_s_ready = 1'b0; a_s_rvalid = 1'b0; a_s_rdata = '0;
    a_m_addr   = {64'h300, 64'h200, 64'h100};
    a_m_wen    = 3'b010;
    a_m_wdata  = {64'hC2, 64'hC1, 64'hC0};
    a_m_wmask  = {8'hF0, 8'h0F, 8'hFF};
    b_m_valid  = '0; b_s_ready = 1'b0; b_s_rvalid = 1'b0; b_s_rdata = '0;
    b_m_addr   = {64'h40, 64'h10};
    b_m_wen    = 2'b00;
    b_m_wdata  = '0;
    b_m_wmask  = '0;

    // Reset state: everything idle
    @(negedge clk);
    do_reset();
    a_s_ready = 1'b1;
    #1;
    chk("rst_s_valid", 64'(a_s_valid), 64'd0);
    chk("rst_m_ready", 64'(a_m_ready), 64'd0);
    chk("rst_m_rvalid", 64'(a_m_rvalid), 64'd0);
    chk("rst_resp_err", 64'(a_resp_err), 64'd0);
    @(negedge clk);

    // Round-robin: grants 0,1,2,0,1,2 with responses one cycle later
    for (int n = 0; n < 6; n++) begin
      a_m_valid  = 3'b111;
      a_s_ready  = 1'b1;
      a_s_rvalid = (n > 0);
      a_s_rdata  = 64'hD0 + 64'(n);
      #1;
      exp_g = n % 3;
      chk("rr_m_ready", 64'(a_m_ready), 64'(1 << exp_g));
      chk("rr_s_addr", 64'(a_s_addr), 64'((exp_g + 1) * 32));
      chk("rr_s_wen", 64'(a_s_wen), 64'(exp_g == 1));
      if (n > 0) begin
        chk("rr_m_rvalid", 64'(a_m_rvalid), 64'(1 << ((n - 1) % 3)));
        chk("rr_m_rdata", a_m_rdata, 64'hD0 + 64'(n));
      end
      @(negedge clk);
    end
    a_m_valid  = 3'b000;
    a_s_rvalid = 1'b1;
    #1;
    chk("rr_last_rvalid", 64'(a_m_rvalid), 64'b100);
    chk("rr_idle_s_valid", 64'(a_s_valid), 64'd0);
    @(negedge clk);

    // FIFO full: two handshakes, then no grant until a pop has retired
    a_s_rvalid = 1'b0;
    a_m_valid  = 3'b010;
    #1;
    chk("full_hs1", 64'(a_m_ready), 64'b010);
    @(negedge clk);
    a_m_valid = 3'b100;
    #1;
    chk("full_hs2", 64'(a_m_ready), 64'b100);
    @(negedge clk);
    a_m_valid = 3'b001;
    #1;
    chk("full_block_s_valid", 64'(a_s_valid), 64'd0);
    chk("full_block_m_ready", 64'(a_m_ready), 64'd0);
    @(negedge clk);
    a_s_rvalid = 1'b1;
    #1;
    chk("full_pop_same_cycle_s_valid", 64'(a_s_valid), 64'd0);
    chk("full_pop_order1", 64'(a_m_rvalid), 64'b010);
    @(negedge clk);
    a_s_rvalid = 1'b0;
    #1;
    chk("full_regrant", 64'(a_m_ready), 64'b001);
    @(negedge clk);
    a_m_valid  = 3'b000;
    a_s_rvalid = 1'b1;
    #1;
    chk("full_pop_order2", 64'(a_m_rvalid), 64'b100);
    @(negedge clk);
    #1;
    chk("full_pop_order3", 64'(a_m_rvalid), 64'b001);
    @(negedge clk);

    // Unexpected response: dropped, sticky error until reset
    #1;
    chk("err_no_rvalid", 64'(a_m_rvalid), 64'd0);
    @(negedge clk);
    a_s_rvalid = 1'b0;
    #1;
    chk("err_set", 64'(a_resp_err), 64'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("err_held", 64'(a_resp_err), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("err_cleared", 64'(a_resp_err), 64'd0);
    @(negedge clk);

    // Fixed priority: ch1 starves ch0 until it drops
    b_s_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      b_m_valid  = 2'b11;
      b_s_rvalid = (n > 0);
      #1;
      chk("fp_ch1_wins", 64'(b_m_ready), 64'b10);
      if (n > 0) begin
        chk("fp_rvalid_ch1", 64'(b_m_rvalid), 64'b10);
      end
      @(negedge clk);
    end
    b_m_valid = 2'b01;
    #1;
    chk("fp_ch0_after_drop", 64'(b_m_ready), 64'b01);
    chk("fp_s_addr_ch0", 64'(b_s_addr), 64'h2);
    @(negedge clk);
    b_m_valid = 2'b00;
    #1;
    chk("fp_rvalid_ch0", 64'(b_m_rvalid), 64'b01);
    @(negedge clk);
    b_s_rvalid = 1'b0;

    // Stall: ch0 locked while slave stalls, even after ch1 raises valid
    b_s_ready = 1'b0;
    b_m_valid = 2'b01;
    #1;
    chk("stall_c0_s_addr", 64'(b_s_addr), 64'h2);
    chk("stall_c0_m_ready", 64'(b_m_ready), 64'd0);
    @(negedge clk);
    b_m_valid = 2'b11;
    for (int n = 0; n < 2; n++) begin
      #1;
      chk("stall_locked_s_addr", 64'(b_s_addr), 64'h2);
      chk("stall_locked_m_ready", 64'(b_m_ready), 64'd0);
      @(negedge clk);
    end
    b_s_ready = 1'b1;
    #1;
    chk("stall_hs_ch0", 64'(b_m_ready), 64'b01);
    chk("stall_hs_s_addr", 64'(b_s_addr), 64'h2);
    @(negedge clk);
    b_m_valid = 2'b10;
    #1;
    chk("stall_then_ch1", 64'(b_m_ready), 64'b10);
    chk("stall_ch1_s_addr", 64'(b_s_addr), 64'h8);
    @(negedge clk);
    b_m_valid  = 2'b00;
    b_s_rvalid = 1'b1;
    #1;
    chk("stall_resp0", 64'(b_m_rvalid), 64'b01);
    @(negedge clk);
    #1;
    chk("stall_resp1", 64'(b_m_rvalid), 64'b10);
    @(negedge clk);
    b_s_rvalid = 1'b0;

`ifdef MEMBUS_ARB_PERF_EN
    do_reset();
    b_m_valid = 2'b01;
    b_s_ready = 1'b0;
    repeat (4) @(negedge clk);
    b_s_ready = 1'b1;
    #1;
    chk("perf_hs", 64'(b_m_ready), 64'b01);
    @(negedge clk);
    b_m_valid  = 2'b00;
    b_s_rvalid = 1'b1;
    #1;
    chk("perf_stalls0", 64'(b_perf_stalls[31:0]), 64'd4);
    chk("perf_grants0", 64'(b_perf_grants[31:0]), 64'd1);
    chk("perf_grants1", 64'(b_perf_grants[63:32]), 64'd0);
    @(negedge clk);
    b_s_rvalid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- N-channel arbiter that multiplexes request buses (instruction fetch, load/store, future DMA/debug) onto one single-port RAM membus slave.
- Supersedes the fixed 2-way I/D arbitration embedded in the top level.
- Adds a channel count parameter, a selectable fixed-priority or round-robin policy, grant locking while the slave stalls, and multiple outstanding requests.
- Routes every response back to its issuer using an in-order channel-ID FIFO.

Parameters:
- NUM_CH, 2: number of requesting channels (2..8).
- XLEN, 64: master address width.
- DATA_WIDTH, 64: RAM data width; wmask width is DATA_WIDTH/8.
- RAM_ADDR_WIDTH, 16: slave word-address width.
- ARB_MODE, 0: 0 = fixed priority (highest channel index wins), 1 = round-robin.
- MAX_OUTSTANDING, 2: depth of the response-routing FIFO (power of two, >=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-low reset
- m_valid  in  NUM_CH  per-channel request valid
- m_ready  out  NUM_CH  per-channel request accepted
- m_addr  in  NUM_CH*XLEN  byte addresses
- m_wen  in  NUM_CH  write enable
- m_wdata  in  NUM_CH*DATA_WIDTH  write data
- m_wmask  in  NUM_CH*DATA_WIDTH/8  byte mask
- m_rvalid  out  NUM_CH  response valid
- m_rdata  out  DATA_WIDTH  response data, shared by all channels
- s_valid  out  1  slave request
- s_ready  in  1  slave accept
- s_addr  out  RAM_ADDR_WIDTH  word address
- s_wen  out  1  slave write enable
- s_wdata  out  DATA_WIDTH  slave write data
- s_wmask  out  DATA_WIDTH/8  slave byte mask
- s_rvalid  in  1  slave response valid
- s_rdata  in  DATA_WIDTH  slave response data
- resp_err  out  1  sticky flag: unexpected response

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-low; all state is updated on posedge clk only.
- Reset state:
  - FIFO empty.
  - Grant lock cleared.
  - Round-robin pointer = NUM_CH-1, so channel 0 wins first.
  - resp_err = 0.
  - All outputs combinationally idle: s_valid = 0, m_ready = 0, m_rvalid = 0.
  - Reset mid-operation discards in-flight routing entries. The slave must also be reset.
- Slave contract: exactly one s_rvalid per accepted request, reads and writes alike, in acceptance order, no earlier than the cycle after acceptance.
- Address conversion: s_addr = m_addr[g][$clog2(DATA_WIDTH/8) +: RAM_ADDR_WIDTH]. Upper bits are ignored.
- Grant selection (combinational, winner g):
  - If the lock is set, g = the locked ID.
  - Otherwise fixed priority, or a round-robin search starting at pointer+1 modulo NUM_CH.
- Request path:
  - s_valid = (any m_valid) && !fifo_full.
  - s_wen, s_wdata and s_wmask come from channel g. When s_wen = 0, s_wdata and s_wmask are don't-care.
  - m_ready[g] = s_ready && !fifo_full; all other m_ready bits are 0.
- Grant lock: if s_valid && !s_ready, register lock = g. Clear the lock on the handshake. The slave therefore never sees addr/data change while stalled.
- Masters must hold valid and payload until ready.
- On a handshake (s_valid && s_ready):
  - Push g into the FIFO.
  - Round-robin pointer <= g.
- Response path:
  - m_rvalid[fifo_head] = s_rvalid; m_rdata = s_rdata.
  - Pop on s_rvalid.
  - Zero added latency: response appears in the same cycle as s_rvalid.
- Boundary conditions:
  - FIFO full: no new grant, even if a pop occurs in the same cycle. This is a deterministic, deliberately conservative rule.
  - Simultaneous push and pop when not full: occupancy is unchanged.
  - s_rvalid with the FIFO empty: the response is dropped, all m_rvalid = 0, and resp_err <= 1 until reset.
  - Pointer wrap-around: after NUM_CH-1 the search wraps to 0.

Optional Feature:
- Macro: MEMBUS_ARB_PERF_EN.
- When defined, adds output perf_grants of NUM_CH*32 bits: per-channel accepted-request counters.
- When defined, adds output perf_stalls of NUM_CH*32 bits: per-channel counts of cycles with m_valid=1 and m_ready=0.
- Counters wrap at 2^32 and reset to 0.
- Without the macro, neither port nor the counter logic exists.

Decomposition:
- Shared package eei holds:
  - ArbMode enum: FIXED, RR.
  - The ChId typedef, logic[$clog2(NUM_CH)-1:0], with a max of 8 channels.
  - The addr-to-RAM-address function, shared with the top level.
- One sub-module: membus_arb_id_fifo. It is a synchronous FIFO of channel IDs with push, pop, full, empty and head.

Test Plan:
- ARB_MODE=1, NUM_CH=3, all valid every cycle, s_ready=1, rvalid one cycle later -> grants 0,1,2,0,1,2; each m_rvalid matches its issuer.
- ARB_MODE=0, ch0 and ch1 both valid -> ch1 is granted every cycle and ch0 starves. Drop ch1 -> ch0 is granted the next cycle.
- Stall: ch0 requests addr 0x10, s_ready=0 for 3 cycles, ch1 raises valid at cycle 1 -> s_addr stays 0x2 and the grant stays ch0 until the handshake; then ch1 is granted.
- MAX_OUTSTANDING=2, slave withholds rvalid -> after 2 handshakes s_valid=0. One rvalid pop -> the next cycle grants again. Responses return in issue order.
- s_rvalid pulse with no outstanding request -> no m_rvalid, resp_err=1 and held; rst=0 for one cycle clears it.
- MEMBUS_ARB_PERF_EN: ch0 stalled 4 cycles then accepted -> perf_stalls[0]=4, perf_grants[0]=1.
